// File: rtl/wb_write_queue.sv
// ---------------------------------------------------------------------------
// wb_write_queue
//   Writeback-side producer for the register file write port. Buffers up to
//   DEPTH results from execute/memory and retires one per cycle. The register
//   file samples on the falling edge of CLK. The write port is driven
//   combinationally from registered state and from wb_stall, so it has settled
//   well before that edge.
//   Also forwards the newest pending value for two read addresses, so decode
//   sees results that are still queued.
//
// Ports
//   CLK, rst_n                 clock (posedge) / async active-low reset
//   in_valid/in_ready          producer handshake; in_ready = !full
//   in_rw, in_data             destination register and value offered
//   wb_stall                   freezes retirement for this cycle
//   reg_write, rw, data        register file write port (head of queue)
//   ra, rb                     read addresses checked for pending writes
//   fwd_{a,b}_hit/_data        newest queued value for ra/rb (0 on miss)
//   count, empty               occupancy
// ---------------------------------------------------------------------------
module wb_write_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input  logic                     CLK,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [AW-1:0]            in_rw,
   input  logic [DW-1:0]            in_data,
   input  logic                     wb_stall,
   output logic                     reg_write,
   output logic [AW-1:0]            rw,
   output logic [DW-1:0]            data,
   input  logic [AW-1:0]            ra,
   input  logic [AW-1:0]            rb,
   output logic                     fwd_a_hit,
   output logic [DW-1:0]            fwd_a_data,
   output logic                     fwd_b_hit,
   output logic [DW-1:0]            fwd_b_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-1:0] ent_rw_q   [DEPTH];
   logic [DW-1:0] ent_data_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q,  count_d;

   logic full;
   logic accept;
   logic push;
   logic pop;

   assign full     = (count_q == CW'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   // Full blocks new offers even if the head retires this cycle.
   assign in_ready = !full;
   assign accept   = in_valid && in_ready;
   // Writes to $zero are handshaken but dropped.
   assign push     = accept && (in_rw != '0);
   assign pop      = reg_write;

   assign reg_write = !empty && !wb_stall;
   assign rw        = empty ? '0 : ent_rw_q[rd_ptr_q];
   assign data      = empty ? '0 : ent_data_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d  = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_rw_q[i]   <= '0;
            ent_data_q[i] <= '0;
         end
      end else begin
         if (push) begin
            ent_rw_q[wr_ptr_q]   <= in_rw;
            ent_data_q[wr_ptr_q] <= in_data;
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Walk occupied entries oldest to newest; a later match overwrites an
   // earlier one, so the most recently pushed entry wins. The head is
   // included, so it keeps forwarding during the cycle its write lands.
   always_comb begin
      fwd_a_hit  = 1'b0;
      fwd_a_data = '0;
      fwd_b_hit  = 1'b0;
      fwd_b_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (CW'(i) < count_q) begin
            if (ra != '0 && ent_rw_q[rd_ptr_q + PW'(i)] == ra) begin
               fwd_a_hit  = 1'b1;
               fwd_a_data = ent_data_q[rd_ptr_q + PW'(i)];
            end
            if (rb != '0 && ent_rw_q[rd_ptr_q + PW'(i)] == rb) begin
               fwd_b_hit  = 1'b1;
               fwd_b_data = ent_data_q[rd_ptr_q + PW'(i)];
            end
         end
      end
   end

endmodule

// File: tb/tb_wb_write_queue.sv
module tb_wb_write_queue;

   logic        CLK = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_rw;
   logic [31:0] in_data;
   logic        wb_stall;
   logic        reg_write;
   logic [4:0]  rw;
   logic [31:0] data;
   logic [4:0]  ra, rb;
   logic        fwd_a_hit, fwd_b_hit;
   logic [31:0] fwd_a_data, fwd_b_data;
   logic [2:0]  count;
   logic        empty;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 CLK = ~CLK;

   wb_write_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
      .CLK(CLK), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_rw(in_rw), .in_data(in_data),
      .wb_stall(wb_stall),
      .reg_write(reg_write), .rw(rw), .data(data),
      .ra(ra), .rb(rb),
      .fwd_a_hit(fwd_a_hit), .fwd_a_data(fwd_a_data),
      .fwd_b_hit(fwd_b_hit), .fwd_b_data(fwd_b_data),
      .count(count), .empty(empty)
   );

   // One vector per cycle: inputs are driven after negedge, outputs are
   // checked before the following posedge commits the push/pop.
   typedef struct {
      logic        rst_n, vld;
      logic [4:0]  irw;
      logic [31:0] idata;
      logic        stall;
      logic [4:0]  ra, rb;
      logic        wr;
      logic [4:0]  rw;
      logic [31:0] data;
      logic        rdy, emp;
      logic [2:0]  cnt;
      logic        ah;
      logic [31:0] ad;
      logic        bh;
      logic [31:0] bd;
   } vec_t;

   localparam int NV = 27;
   vec_t tbl [NV];

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      int pushed, retired, cyc;

      //          rst vld rw  data          stl ra  rb | wr rw  data          rdy emp cnt ah ad            bh bd
      // reset
      tbl[0]  = '{0, 0, 5'd0, 32'h0,        0, 5'd0, 5'd0,  0, 5'd0, 32'h0,        1, 1, 3'd0, 0, 32'h0,        0, 32'h0};
      // single write, no bypass, head forwards while writing
      tbl[1]  = '{1, 1, 5'd5, 32'hDEADBEEF, 0, 5'd5, 5'd0,  0, 5'd0, 32'h0,        1, 1, 3'd0, 0, 32'h0,        0, 32'h0};
      tbl[2]  = '{1, 0, 5'd0, 32'h0,        0, 5'd5, 5'd0,  1, 5'd5, 32'hDEADBEEF, 1, 0, 3'd1, 1, 32'hDEADBEEF, 0, 32'h0};
      tbl[3]  = '{1, 0, 5'd0, 32'h0,        0, 5'd5, 5'd0,  0, 5'd0, 32'h0,        1, 1, 3'd0, 0, 32'h0,        0, 32'h0};
      // fill under stall, forwarding priority, full rejects offers
      tbl[4]  = '{1, 1, 5'd7, 32'h11,       1, 5'd0, 5'd0,  0, 5'd0, 32'h0,        1, 1, 3'd0, 0, 32'h0,        0, 32'h0};
      tbl[5]  = '{1, 1, 5'd7, 32'h22,       1, 5'd7, 5'd8,  0, 5'd7, 32'h11,       1, 0, 3'd1, 1, 32'h11,       0, 32'h0};
      tbl[6]  = '{1, 1, 5'd3, 32'h33,       1, 5'd7, 5'd8,  0, 5'd7, 32'h11,       1, 0, 3'd2, 1, 32'h22,       0, 32'h0};
      tbl[7]  = '{1, 1, 5'd9, 32'h44,       1, 5'd3, 5'd9,  0, 5'd7, 32'h11,       1, 0, 3'd3, 1, 32'h33,       0, 32'h0};
      tbl[8]  = '{1, 1, 5'd10, 32'h55,      1, 5'd7, 5'd9,  0, 5'd7, 32'h11,       0, 0, 3'd4, 1, 32'h22,       1, 32'h44};
      tbl[9]  = '{1, 1, 5'd12, 32'h66,      0, 5'd0, 5'd0,  1, 5'd7, 32'h11,       0, 0, 3'd4, 0, 32'h0,        0, 32'h0};
      tbl[10] = '{1, 0, 5'd0, 32'h0,        0, 5'd0, 5'd0,  1, 5'd7, 32'h22,       1, 0, 3'd3, 0, 32'h0,        0, 32'h0};
      tbl[11] = '{1, 0, 5'd0, 32'h0,        0, 5'd0, 5'd0,  1, 5'd3, 32'h33,       1, 0, 3'd2, 0, 32'h0,        0, 32'h0};
      tbl[12] = '{1, 0, 5'd0, 32'h0,        0, 5'd9, 5'd0,  1, 5'd9, 32'h44,       1, 0, 3'd1, 1, 32'h44,       0, 32'h0};
      tbl[13] = '{1, 0, 5'd0, 32'h0,        0, 5'd0, 5'd0,  0, 5'd0, 32'h0,        1, 1, 3'd0, 0, 32'h0,        0, 32'h0};
      // $zero is accepted but dropped, never forwards
      tbl[14] = '{1, 1, 5'd0, 32'hFFFF,     0, 5'd0, 5'd0,  0, 5'd0, 32'h0,        1, 1, 3'd0, 0, 32'h0,        0, 32'h0};
      tbl[15] = '{1, 0, 5'd0, 32'h0,        0, 5'd0, 5'd0,  0, 5'd0, 32'h0,        1, 1, 3'd0, 0, 32'h0,        0, 32'h0};
      // simultaneous push and pop keeps count
      tbl[16] = '{1, 1, 5'd4, 32'hA1,       0, 5'd0, 5'd0,  0, 5'd0, 32'h0,        1, 1, 3'd0, 0, 32'h0,        0, 32'h0};
      tbl[17] = '{1, 1, 5'd6, 32'hA2,       0, 5'd4, 5'd6,  1, 5'd4, 32'hA1,       1, 0, 3'd1, 1, 32'hA1,       0, 32'h0};
      tbl[18] = '{1, 0, 5'd0, 32'h0,        0, 5'd0, 5'd6,  1, 5'd6, 32'hA2,       1, 0, 3'd1, 0, 32'h0,        1, 32'hA2};
      tbl[19] = '{1, 0, 5'd0, 32'h0,        0, 5'd0, 5'd0,  0, 5'd0, 32'h0,        1, 1, 3'd0, 0, 32'h0,        0, 32'h0};
      // reset with three pending writes discards them
      tbl[20] = '{1, 1, 5'd1, 32'hB1,       1, 5'd0, 5'd0,  0, 5'd0, 32'h0,        1, 1, 3'd0, 0, 32'h0,        0, 32'h0};
      tbl[21] = '{1, 1, 5'd2, 32'hB2,       1, 5'd0, 5'd0,  0, 5'd1, 32'hB1,       1, 0, 3'd1, 0, 32'h0,        0, 32'h0};
      tbl[22] = '{1, 1, 5'd3, 32'hB3,       1, 5'd0, 5'd0,  0, 5'd1, 32'hB1,       1, 0, 3'd2, 0, 32'h0,        0, 32'h0};
      tbl[23] = '{1, 0, 5'd0, 32'h0,        1, 5'd2, 5'd0,  0, 5'd1, 32'hB1,       1, 0, 3'd3, 1, 32'hB2,       0, 32'h0};
      tbl[24] = '{0, 1, 5'd4, 32'hB4,       0, 5'd2, 5'd0,  0, 5'd0, 32'h0,        1, 1, 3'd0, 0, 32'h0,        0, 32'h0};
      tbl[25] = '{1, 0, 5'd0, 32'h0,        0, 5'd2, 5'd0,  0, 5'd0, 32'h0,        1, 1, 3'd0, 0, 32'h0,        0, 32'h0};
      tbl[26] = '{1, 0, 5'd0, 32'h0,        0, 5'd2, 5'd0,  0, 5'd0, 32'h0,        1, 1, 3'd0, 0, 32'h0,        0, 32'h0};

      rst_n = 1'b0; in_valid = 1'b0; in_rw = '0; in_data = '0;
      wb_stall = 1'b0; ra = '0; rb = '0;

      for (int k = 0; k < NV; k++) begin
         @(negedge CLK);
         rst_n    = tbl[k].rst_n;
         in_valid = tbl[k].vld;
         in_rw    = tbl[k].irw;
         in_data  = tbl[k].idata;
         wb_stall = tbl[k].stall;
         ra       = tbl[k].ra;
         rb       = tbl[k].rb;
         #1;
         cmp($sformatf("v%0d.reg_write", k), 32'(reg_write), 32'(tbl[k].wr));
         cmp($sformatf("v%0d.rw", k),        32'(rw),        32'(tbl[k].rw));
         cmp($sformatf("v%0d.data", k),      data,           tbl[k].data);
         cmp($sformatf("v%0d.in_ready", k),  32'(in_ready),  32'(tbl[k].rdy));
         cmp($sformatf("v%0d.empty", k),     32'(empty),     32'(tbl[k].emp));
         cmp($sformatf("v%0d.count", k),     32'(count),     32'(tbl[k].cnt));
         cmp($sformatf("v%0d.fwd_a_hit", k), 32'(fwd_a_hit), 32'(tbl[k].ah));
         cmp($sformatf("v%0d.fwd_a_data", k), fwd_a_data,    tbl[k].ad);
         cmp($sformatf("v%0d.fwd_b_hit", k), 32'(fwd_b_hit), 32'(tbl[k].bh));
         cmp($sformatf("v%0d.fwd_b_data", k), fwd_b_data,    tbl[k].bd);
      end

      // 10 back-to-back pushes with random stalls: in-order retirement,
      // occupancy bounded, pointers wrap.
      pushed = 0; retired = 0; cyc = 0;
      ra = '0; rb = '0;
      while ((pushed < 10 || retired < 10) && cyc < 200) begin
         @(negedge CLK);
         in_valid = (pushed < 10);
         in_rw    = 5'(pushed + 1);
         in_data  = 32'h100 + 32'(pushed);
         wb_stall = ($urandom_range(0, 2) == 0);
         #1;
         cmp($sformatf("wrap.c%0d.count_le4", cyc), 32'(count <= 3'd4), 32'd1);
         if (reg_write) begin
            cmp($sformatf("wrap.w%0d.rw", retired),   32'(rw), 32'(retired + 1));
            cmp($sformatf("wrap.w%0d.data", retired), data,    32'h100 + 32'(retired));
            retired++;
         end
         if (in_valid && in_ready) pushed++;
         cyc++;
      end
      cmp("wrap.retired", 32'(retired), 32'd10);
      cmp("wrap.pushed",  32'(pushed),  32'd10);
      @(negedge CLK);
      in_valid = 1'b0; wb_stall = 1'b0;
      #1;
      cmp("wrap.final_empty", 32'(empty), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
